// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default width.
package seq_div_pkg;

    localparam int N_DEF = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_TEST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/seq_div_control.sv
// Control FSM of the sequential divider: sequences load, shift/test steps and the done pulse.
module seq_div_control
    import seq_div_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic zero_div,
    input  logic h_ge_d,
    input  logic cnt_zero,
    output logic load,
    output logic shift,
    output logic sub,
    output logic set_dbz,
    output logic set_ovf,
    output logic fin,
    output logic done,
    output logic busy
);

    logic [2:0] state;
    logic [2:0] state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CHECK;
            S_CHECK: begin
                if (zero_div || h_ge_d) state_nxt = S_DONE;
                else                    state_nxt = S_SHIFT;
            end
            S_SHIFT: state_nxt = S_TEST;
            S_TEST:  state_nxt = cnt_zero ? S_DONE : S_SHIFT;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // fin marks the edge that enters DONE, so results are in place during the done pulse.
    always_comb begin
        load    = 1'b0;
        shift   = 1'b0;
        sub     = 1'b0;
        set_dbz = 1'b0;
        set_ovf = 1'b0;
        fin     = 1'b0;
        done    = 1'b0;
        busy    = 1'b0;
        case (state)
            S_IDLE:  load = start;
            S_CHECK: begin
                busy    = 1'b1;
                set_dbz = zero_div;
                set_ovf = !zero_div && h_ge_d;
                fin     = zero_div || h_ge_d;
            end
            S_SHIFT: begin
                busy  = 1'b1;
                shift = 1'b1;
            end
            S_TEST: begin
                busy = 1'b1;
                sub  = 1'b1;
                fin  = cnt_zero;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider datapath: 2N-bit dividend / N-bit divisor, one quotient bit per SHIFT/TEST pair.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           dbz,
    output logic           ovf
);

    localparam int CW = $clog2(N + 1);

    logic [N:0]    h;
    logic [N-1:0]  l;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;

    logic          load, shift, sub, set_dbz, set_ovf, fin;
    logic          zero_div, h_ge_d, cnt_zero;
    logic [N:0]    d_ext, h_diff, h_test;
    logic [N-1:0]  l_test;
    logic [CW-1:0] cnt_dec;

    // One comparator serves both the overflow check in CHECK and the trial subtraction in TEST.
    always_comb begin
        d_ext    = {1'b0, d};
        zero_div = (d == '0);
        h_ge_d   = (h >= d_ext);
        h_diff   = h - d_ext;
        h_test   = h_ge_d ? h_diff : h;
        l_test   = {l[N-1:1], h_ge_d};
        cnt_dec  = cnt - CW'(1);
        cnt_zero = (cnt_dec == '0);
    end

    seq_div_control u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .zero_div (zero_div),
        .h_ge_d   (h_ge_d),
        .cnt_zero (cnt_zero),
        .load     (load),
        .shift    (shift),
        .sub      (sub),
        .set_dbz  (set_dbz),
        .set_ovf  (set_ovf),
        .fin      (fin),
        .done     (done),
        .busy     (busy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h   <= '0;
            l   <= '0;
            d   <= '0;
            cnt <= '0;
        end else if (load) begin
            h   <= {1'b0, dividend[2*N-1:N]};
            l   <= dividend[N-1:0];
            d   <= divisor;
            cnt <= CW'(N);
        end else if (shift) begin
            h   <= {h[N-1:0], l[N-1]};
            l   <= {l[N-2:0], 1'b0};
        end else if (sub) begin
            h   <= h_test;
            l   <= l_test;
            cnt <= cnt_dec;
        end
    end

    // Results update only on entry to DONE and hold across later acceptances until the next DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (load) begin
                dbz <= 1'b0;
                ovf <= 1'b0;
            end else begin
                if (set_dbz) dbz <= 1'b1;
                if (set_ovf) ovf <= 1'b1;
            end
            if (fin) begin
                if (set_dbz || set_ovf) begin
                    quotient  <= '1;
                    remainder <= '0;
                end else begin
                    quotient  <= l_test;
                    remainder <= h_test[N-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (N = 4): directed divisions, early exits, busy-time noise, back-to-back and async reset.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy, done, dbz, ovf;
    logic [3:0] quotient, remainder;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        logic       ovf;
        int         acc;
        int         lat;
    } exp_t;

    exp_t sb[$];

    seq_divider #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", int'(quotient), int'(e.q));
                chk("remainder", int'(remainder), int'(e.r));
                chk("dbz", int'(dbz), int'(e.dbz));
                chk("ovf", int'(ovf), int'(e.ovf));
                chk("latency", cyc - e.acc, e.lat);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 50; k++) begin
            if (!busy && !done) break;
            @(negedge clk);
        end
    endtask

    task automatic push(input logic [3:0] q, input logic [3:0] r, input logic edbz,
                        input logic eovf, input int acc, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.dbz = edbz; e.ovf = eovf; e.acc = acc; e.lat = lat;
        sb.push_back(e);
    endtask

    // Waits for done with a bound; checks busy while waiting and optionally jitters start/operands.
    task automatic wait_done(input bit toggle, output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            chk("busy_while_running", int'(busy), 1);
            if (toggle) begin
                start    = 1'($urandom_range(0, 1));
                dividend = 8'($urandom);
                divisor  = 4'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
    endtask

    task automatic do_div(input logic [7:0] a, input logic [3:0] dv, input logic [3:0] eq,
                          input logic [3:0] er, input logic edbz, input logic eovf,
                          input int lat, input bit toggle);
        bit got;
        wait_idle();
        dividend = a;
        divisor  = dv;
        start    = 1'b1;
        push(eq, er, edbz, eovf, cyc + 1, lat);
        @(negedge clk);
        start = 1'b0;
        chk("flags_cleared_dbz", int'(dbz), 0);
        chk("flags_cleared_ovf", int'(ovf), 0);
        wait_done(toggle, got);
        @(negedge clk);
        chk("hold_done_low", int'(done), 0);
        chk("hold_quotient", int'(quotient), int'(eq));
        chk("hold_remainder", int'(remainder), int'(er));
        chk("hold_dbz", int'(dbz), int'(edbz));
        chk("hold_ovf", int'(ovf), int'(eovf));
    endtask

    initial begin
        bit got;
        int acc1;
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(dbz), 0);
        chk("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_div(8'd117, 4'd9,  4'd13, 4'd0,  1'b0, 1'b0, 9, 1'b0);
        do_div(8'd100, 4'd7,  4'd14, 4'd2,  1'b0, 1'b0, 9, 1'b0);
        do_div(8'd239, 4'd15, 4'd15, 4'd14, 1'b0, 1'b0, 9, 1'b0);
        do_div(8'd50,  4'd0,  4'd15, 4'd0,  1'b1, 1'b0, 1, 1'b0);
        do_div(8'd200, 4'd12, 4'd15, 4'd0,  1'b0, 1'b1, 1, 1'b0);
        do_div(8'd0,   4'd5,  4'd0,  4'd0,  1'b0, 1'b0, 9, 1'b0);
        do_div(8'd100, 4'd7,  4'd14, 4'd2,  1'b0, 1'b0, 9, 1'b1);

        // start held high: second division is accepted on the first IDLE edge after DONE
        wait_idle();
        dividend = 8'd117;
        divisor  = 4'd9;
        start    = 1'b1;
        acc1     = cyc + 1;
        push(4'd13, 4'd0, 1'b0, 1'b0, acc1, 9);
        push(4'd15, 4'd14, 1'b0, 1'b0, acc1 + 11, 9);
        @(negedge clk);
        dividend = 8'd239;
        divisor  = 4'd15;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk("b2b_first_done", int'(done), 1);
        @(negedge clk);
        chk("b2b_idle_gap_done", int'(done), 0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_busy", int'(busy), 1);
        wait_done(1'b0, got);
        @(negedge clk);

        // async reset in the middle of TEST abandons the division
        wait_idle();
        dividend = 8'd117;
        divisor  = 4'd9;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_quotient", int'(quotient), 0);
        chk("arst_remainder", int'(remainder), 0);
        chk("arst_dbz", int'(dbz), 0);
        chk("arst_ovf", int'(ovf), 0);
        @(negedge clk);
        @(negedge clk);
        chk("arst_held_done", int'(done), 0);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", int'(done), 0);
        end

        do_div(8'd117, 4'd9, 4'd13, 4'd0, 1'b0, 1'b0, 9, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
